// File: rtl/print_char_tx.sv
// Debug-print transmitter: Wishbone-written characters are queued and framed onto an 8-bit pad bus with a strobe.
// Define PRINT_TX_CRLF_EN to send an automatic CR frame ahead of every LF.
module print_char_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
    parameter int          FIFO_DEPTH = 16,
    parameter int          SETUP_CYC  = 2,
    parameter int          STROBE_CYC = 4,
    parameter int          HOLD_CYC   = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  char_o,
    output logic        strobe_o,
    output logic [8:0]  io_oeb_o,
    output logic        eot_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int CW = 16;
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [LW-1:0] LEVEL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] SETUP_LD    = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD   = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD     = CW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [7:0]    char_reg;
    logic          strobe_reg;
    logic          eot_reg;
    logic          ack_reg;
    logic          served_reg;
    logic          ovf_reg;
    logic [31:0]   dat_o_reg;
    logic [8:0]    oeb_reg;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;

    logic          hit_data;
    logic          hit_status;
    logic          wb_req;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          empty;
    logic          busy;
    logic          ovf_clr;
    logic          insert_cr;
    logic [7:0]    head;
    logic [7:0]    level_byte;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign hit_data    = (wbs_adr_i == BASE_ADDR);
    assign hit_status  = (wbs_adr_i == STATUS_ADDR);
    // served_reg blocks a second ack while the master keeps the same request asserted
    assign wb_req      = wbs_cyc_i & wbs_stb_i & (hit_data | hit_status) & ~served_reg;
    assign push_req    = wb_req & wbs_we_i & hit_data & wbs_sel_i[0];
    assign ovf_clr     = wb_req & wbs_we_i & hit_status & wbs_dat_i[3];
    assign full        = (level_reg == LEVEL_FULL);
    assign empty       = (level_reg == '0);
    assign push_ok     = push_req & ~full;
    assign head        = mem[rd_ptr_reg];
    assign busy        = (state_reg != IDLE) | ~empty;
    assign level_byte  = 8'(level_reg);
    assign status_word = {16'h0000, level_byte, 4'h0, ovf_reg, busy, empty, full};
    assign unused_bits = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:8]};

`ifdef PRINT_TX_CRLF_EN
    logic cr_sent_reg;
    // An LF at the head is held back until its CR frame has been sent
    assign insert_cr = (head == 8'h0A) & ~cr_sent_reg;
`else
    assign insert_cr = 1'b0;
`endif

    assign pop = (state_reg == IDLE) & ~empty & ~insert_cr;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            ack_reg    <= 1'b0;
            served_reg <= 1'b0;
            dat_o_reg  <= '0;
            ovf_reg    <= 1'b0;
            oeb_reg    <= 9'h1FF;
        end else begin
            ack_reg    <= wb_req;
            served_reg <= wbs_cyc_i & wbs_stb_i & (served_reg | wb_req);
            dat_o_reg  <= (wb_req && !wbs_we_i && hit_status) ? status_word : 32'h0;
            if (push_req && full) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
            oeb_reg    <= 9'h000;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wbs_dat_i[7:0];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_reg + LW'(push_ok) - LW'(pop);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            char_reg   <= '0;
            strobe_reg <= 1'b0;
            eot_reg    <= 1'b0;
`ifdef PRINT_TX_CRLF_EN
            cr_sent_reg <= 1'b0;
`endif
        end else begin
            eot_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!empty) begin
                        char_reg  <= insert_cr ? 8'h0D : head;
`ifdef PRINT_TX_CRLF_EN
                        cr_sent_reg <= insert_cr;
`endif
                        cnt_reg   <= SETUP_LD;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_reg == '0) begin
                        strobe_reg <= 1'b1;
                        eot_reg    <= (char_reg == 8'h04);
                        cnt_reg    <= STROBE_LD;
                        state_reg  <= STROBE;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                STROBE: begin
                    if (cnt_reg == '0) begin
                        strobe_reg <= 1'b0;
                        cnt_reg    <= HOLD_LD;
                        state_reg  <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_o_reg;
    assign char_o    = char_reg;
    assign strobe_o  = strobe_reg;
    assign io_oeb_o  = oeb_reg;
    assign eot_o     = eot_reg;

endmodule

// File: tb/tb_print_char_tx.sv
// Bench for print_char_tx: directed Wishbone traffic, scoreboard of expected characters checked at each strobe rise.
`timescale 1ns/1ps
module tb_print_char_tx;
    localparam logic [31:0] DATA_ADR = 32'h3000_0100;
    localparam logic [31:0] STAT_ADR = 32'h3000_0104;
    localparam int DEPTH  = 16;
    localparam int SETUP  = 2;
    localparam int STRB   = 60;
    localparam int HOLD   = 2;
    localparam int PERIOD = 1 + SETUP + STRB + HOLD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic [7:0]  char_o;
    logic        strobe;
    logic [8:0]  oeb;
    logic        eot;

    always #5 clk = ~clk;

    print_char_tx #(
        .BASE_ADDR(DATA_ADR), .FIFO_DEPTH(DEPTH),
        .SETUP_CYC(SETUP), .STROBE_CYC(STRB), .HOLD_CYC(HOLD)
    ) dut (
        .wb_clk_i(clk), .wb_rstn_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
        .char_o(char_o), .strobe_o(strobe), .io_oeb_o(oeb), .eot_o(eot)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: scoreboard pop, setup/hold stability, strobe width, eot, period
    logic       prev_strobe = 1'b0;
    logic [7:0] prev_char = 8'h00;
    logic [7:0] hold_char = 8'h00;
    logic [7:0] exp_char;
    int stable = 0, high_cnt = 0, hold_left = 0, since_rise = 0;
    int eot_count = 0, fall_count = 0;
    bit rise, fall, rise_seen = 1'b0, period_chk = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            prev_strobe = 1'b0;
            hold_left   = 0;
            high_cnt    = 0;
            stable      = 0;
            rise_seen   = 1'b0;
            prev_char   = char_o;
        end else begin
            rise = strobe && !prev_strobe;
            fall = !strobe && prev_strobe;
            since_rise++;
            if (char_o == prev_char) stable++;
            else stable = 0;
            if (hold_left > 0) begin
                check("hold_stable", 32'(char_o), 32'(hold_char));
                hold_left--;
            end
            check("eot", 32'(eot), 32'(rise && char_o == 8'h04));
            if (eot) eot_count++;
            if (rise) begin
                $display("strobe rise: char=%02h eot=%0b", char_o, eot);
                check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_char = exp_q.pop_front();
                    check("char", 32'(char_o), 32'(exp_char));
                end
                check("setup_stable", 32'(stable >= SETUP), 32'd1);
                if (period_chk && rise_seen) check("period", 32'(since_rise), 32'(PERIOD));
                rise_seen  = 1'b1;
                since_rise = 0;
                high_cnt   = 0;
            end
            if (strobe) high_cnt++;
            if (fall) begin
                check("strobe_width", 32'(high_cnt), 32'(STRB));
                hold_left = HOLD;
                hold_char = char_o;
                fall_count++;
            end
            prev_strobe = strobe;
            prev_char   = char_o;
        end
    end

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = a; dat_w = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 8);
        check("wr_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("wb write adr=%08h dat=%08h", a, d);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = a;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 8);
        check("rd_ack", 32'(ack), 32'd1);
        d = dat_r;
        cyc = 1'b0; stb = 1'b0;
        $display("wb read  adr=%08h dat=%08h", a, d);
    endtask

    task automatic held_req(input logic [31:0] a, input logic w, output int acks);
        acks = 0;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = a; dat_w = 32'h55;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("wb held  adr=%08h we=%0b acks=%0d", a, w, acks);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            #2;
            n++;
        end
        repeat (PERIOD) @(posedge clk);
        #2;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Returns on the negedge after the next strobe fall; a following
    // wb_write preceded by HOLD-1 posedges lands its push on the pop edge.
    task automatic wait_fall();
        int start = fall_count;
        int n = 0;
        while (fall_count == start && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("fall_seen", 32'(fall_count != start), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] r;
    int acks;
    int n;

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_char", 32'(char_o), 32'h0);
        check("rst_strobe", 32'(strobe), 32'h0);
        check("rst_eot", 32'(eot), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", dat_r, 32'h0);
        check("rst_oeb", 32'(oeb), 32'h1FF);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_oeb", 32'(oeb), 32'h1FF);
        @(posedge clk);
        #1;
        check("oeb_enabled", 32'(oeb), 32'h000);

        wb_read(STAT_ADR, r);
        check("status_idle", r, 32'h0000_0002);
        wb_read(DATA_ADR, r);
        check("data_read", r, 32'h0);

        // "Hi" + end-of-test
        eot_count = 0;
        exp_q.push_back(8'h48); exp_q.push_back(8'h69); exp_q.push_back(8'h04);
        wb_write(DATA_ADR, 32'h48);
        wb_write(DATA_ADR, 32'h69);
        wb_write(DATA_ADR, 32'h04);
        wait_drain("drain_hi");
        check("eot_count", 32'(eot_count), 32'd1);

        // Held requests: one ack each, one push; unmapped address never acked
        held_req(STAT_ADR, 1'b0, acks);
        check("held_read_acks", 32'(acks), 32'd1);
        exp_q.push_back(8'h55);
        held_req(DATA_ADR, 1'b1, acks);
        check("held_write_acks", 32'(acks), 32'd1);
        held_req(DATA_ADR + 32'd8, 1'b1, acks);
        check("bad_adr_acks", 32'(acks), 32'd0);
        wait_drain("drain_held");

        // Overflow: first byte is popped at once, next 16 fill the FIFO, last is dropped
        period_chk = 1'b1;
        rise_seen  = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i < 17) exp_q.push_back(8'(8'h41 + i));
            wb_write(DATA_ADR, 32'h41 + 32'(i));
        end
        wb_read(STAT_ADR, r);
        check("status_full_ovf", r, 32'h0000_100D);
        wb_write(STAT_ADR, 32'h8);
        wb_read(STAT_ADR, r);
        check("status_ovf_clear", r, 32'h0000_1005);

        // Push to a full FIFO on the pop edge is dropped
        wait_fall();
        repeat (HOLD - 1) @(posedge clk);
        wb_write(DATA_ADR, 32'h61);
        wb_read(STAT_ADR, r);
        check("status_full_pop_drop", r, 32'h0000_0F0C);
        wb_write(STAT_ADR, 32'h8);

        // Push at level DEPTH-1 on the pop edge is kept
        wait_fall();
        repeat (HOLD - 1) @(posedge clk);
        exp_q.push_back(8'h62);
        wb_write(DATA_ADR, 32'h62);
        wb_read(STAT_ADR, r);
        check("status_push_pop", r, 32'h0000_0F04);
        wait_drain("drain_overflow");
        period_chk = 1'b0;
        wb_read(STAT_ADR, r);
        check("status_drained", r, 32'h0000_0002);

        // Push into an empty FIFO is popped on the following edge
        exp_q.push_back(8'h63);
        wb_write(DATA_ADR, 32'h63);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!strobe && n < 40);
        check("empty_push_latency", 32'(n), 32'(SETUP + 1));
        wait_drain("drain_empty_push");

        // Reset while strobing drops strobe immediately and empties the FIFO
        exp_q.push_back(8'h71); exp_q.push_back(8'h72);
        wb_write(DATA_ADR, 32'h71);
        wb_write(DATA_ADR, 32'h72);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!strobe && n < 40);
        check("strobe_before_reset", 32'(strobe), 32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_strobe", 32'(strobe), 32'd0);
        check("async_char", 32'(char_o), 32'd0);
        check("async_oeb", 32'(oeb), 32'h1FF);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("oeb_after_reset", 32'(oeb), 32'h000);
        wb_read(STAT_ADR, r);
        check("status_after_reset", r, 32'h0000_0002);
        repeat (3 * PERIOD) @(posedge clk);

        // Line feed
`ifdef PRINT_TX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
        wb_write(DATA_ADR, 32'h0A);
        wait_drain("drain_lf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
